// File: rtl/adiabatic_pclk_seq_if.sv
// Control and power-clock bundle for the adiabatic power-clock sequencer.
// en/stop_req are level requests sampled on every clk rising edge; stop_ack answers with a one-cycle pulse.
interface adiabatic_pclk_seq_if #(
    parameter int NSTAGE = 4,
    parameter int TICK_W = 8,
    parameter int CNT_W  = 16
);
    logic                  en;
    logic [TICK_W-1:0]     div;
    logic                  stop_req;
    logic                  busy;
    logic                  stop_ack;
    logic [2*NSTAGE-1:0]   phase;
    logic [NSTAGE-1:0]     pc_up;
    logic [NSTAGE-1:0]     pc_hi;
    logic [NSTAGE-1:0]     pc_dn;
    logic [CNT_W-1:0]      cycle_cnt;
    // Debug view: sequencer state (0 OFF, 1 FILL, 2 RUN, 3 DRAIN) and pending stop.
    logic [1:0]            dbg_state;
    logic                  dbg_stop_pend;

    modport master (
        output en, div, stop_req,
        input  busy, stop_ack, phase, pc_up, pc_hi, pc_dn, cycle_cnt, dbg_state, dbg_stop_pend
    );

    modport slave (
        input  en, div, stop_req,
        output busy, stop_ack, phase, pc_up, pc_hi, pc_dn, cycle_cnt, dbg_state, dbg_stop_pend
    );
endinterface

// File: rtl/adiabatic_pclk_seq.sv
// Four-phase trapezoidal power-clock sequencer: stage k lags stage k-1 by one phase,
// fills stage by stage on start and drains in wavefront order on stop.
module adiabatic_pclk_seq #(
    parameter int NSTAGE = 4,
    parameter int TICK_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adiabatic_pclk_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_FILL  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            gph_q, gph_d;
    logic [NSTAGE-1:0]     active_q, active_d;
    logic [TICK_W-1:0]     tick_q, tick_d;
    logic [TICK_W-1:0]     div_q, div_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic [2*NSTAGE-1:0]   phase_q, phase_d;
    logic [NSTAGE-1:0]     up_q, up_d;
    logic [NSTAGE-1:0]     hi_q, hi_d;
    logic [NSTAGE-1:0]     dn_q, dn_d;

    logic                  adv;
    logic [NSTAGE-1:0]     wrap_mask;
    logic [NSTAGE-1:0]     kill_mask;
    logic [NSTAGE-1:0]     fill_bit;
    logic [NSTAGE-1:0]     drain_act;
    logic [1:0]            ph;

    always_comb begin
        adv = (tick_q == div_q);
        wrap_mask = '0;
        for (int k = 0; k < NSTAGE; k++) begin
            wrap_mask[k] = active_q[k] && ((gph_q - 2'(k)) == 2'd0);
        end
        // A stage about to re-enter UP is dropped once its predecessor is gone (stage 0 has none).
        kill_mask = wrap_mask & ~{active_q[NSTAGE-2:0], 1'b0};
        fill_bit  = ~active_q & (active_q + NSTAGE'(1));
        drain_act = adv ? (active_q & ~kill_mask) : active_q;

        state_d     = state_q;
        gph_d       = gph_q;
        active_d    = active_q;
        tick_d      = tick_q;
        div_d       = div_q;
        stop_pend_d = stop_pend_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;

        if (state_q != S_OFF) begin
            tick_d = adv ? '0 : tick_q + 1'b1;
            if (adv) begin
                gph_d = gph_q + 2'd1;
                if (active_q[0] && gph_q == 2'd3) cnt_d = cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_OFF: begin
                if (bus.stop_req) begin
                    ack_d = 1'b1;
                end else if (bus.en) begin
                    state_d  = S_FILL;
                    div_d    = bus.div;
                    gph_d    = 2'd1;
                    active_d = NSTAGE'(1);
                    tick_d   = '0;
                    cnt_d    = '0;
                end
            end
            S_FILL, S_RUN: begin
                // The edge that sees the stop already applies drain rules: no new ramp ever starts.
                if (bus.stop_req || stop_pend_q) begin
                    active_d    = drain_act;
                    stop_pend_d = 1'b1;
                    state_d     = S_DRAIN;
                    if (drain_act == '0) begin
                        state_d     = S_OFF;
                        ack_d       = 1'b1;
                        stop_pend_d = 1'b0;
                    end
                end else if (state_q == S_FILL && adv) begin
                    active_d = active_q | fill_bit;
                    if (fill_bit[NSTAGE-1]) state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                active_d = drain_act;
                if (drain_act == '0) begin
                    state_d     = S_OFF;
                    ack_d       = 1'b1;
                    stop_pend_d = 1'b0;
                end
            end
            default: state_d = S_OFF;
        endcase

        busy_d  = (state_d != S_OFF);
        phase_d = '0;
        up_d    = '0;
        hi_d    = '0;
        dn_d    = '0;
        ph      = 2'd0;
        for (int k = 0; k < NSTAGE; k++) begin
            ph = gph_d - 2'(k);
            if (active_d[k]) begin
                phase_d[2*k +: 2] = ph;
                up_d[k] = (ph == 2'd1);
                hi_d[k] = (ph == 2'd2);
                dn_d[k] = (ph == 2'd3);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_OFF;
            gph_q       <= 2'd0;
            active_q    <= '0;
            tick_q      <= '0;
            div_q       <= '0;
            stop_pend_q <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            phase_q     <= '0;
            up_q        <= '0;
            hi_q        <= '0;
            dn_q        <= '0;
        end else begin
            state_q     <= state_d;
            gph_q       <= gph_d;
            active_q    <= active_d;
            tick_q      <= tick_d;
            div_q       <= div_d;
            stop_pend_q <= stop_pend_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            phase_q     <= phase_d;
            up_q        <= up_d;
            hi_q        <= hi_d;
            dn_q        <= dn_d;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.stop_ack      = ack_q;
    assign bus.phase         = phase_q;
    assign bus.pc_up         = up_q;
    assign bus.pc_hi         = hi_q;
    assign bus.pc_dn         = dn_q;
    assign bus.cycle_cnt     = cnt_q;
    assign bus.dbg_state     = state_q;
    assign bus.dbg_stop_pend = stop_pend_q;
endmodule
